vga_scan_timing: RTL



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_scan_timing_if.sv | 25 ++
 rtl/vga_scan_timing_scan_counter.sv | 31 +++
 rtl/vga_scan_timing.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA scan timing block.
// Holds the default 800x600@72 timing, the coordinate widths and the
// sync polarity encoding used by vga_scan_timing and its interface.
package vga_timing_pkg;

    localparam int unsigned DEF_HSW  = 120;
    localparam int unsigned DEF_HBP  = 64;
    localparam int unsigned DEF_HACT = 800;
    localparam int unsigned DEF_HFP  = 56;
    localparam int unsigned DEF_VSW  = 6;
    localparam int unsigned DEF_VBP  = 23;
    localparam int unsigned DEF_VACT = 600;
    localparam int unsigned DEF_VFP  = 37;

    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    // Asserted level of hs/vs for the usual negative-sync modes.
    localparam bit SYNC_ACTIVE_LOW = 1'b0;

    // Total length of one axis: sync + back porch + active + front porch.
    function automatic int unsigned axis_total(input int unsigned sw, input int unsigned bp,
                                               input int unsigned act, input int unsigned fp);
        return sw + bp + act + fp;
    endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Raster timing bundle produced by vga_scan_timing.
//   master: driven by the timing generator
//   slave : consumed by pixel/display logic
// Signals: hs, vs, hen, ven, x, y, line_end, frame_start.
interface vga_scan_timing_if;
    import vga_timing_pkg::*;

    logic           hs;
    logic           vs;
    logic           hen;
    logic           ven;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_end;
    logic           frame_start;

    modport master (
        output hs, vs, hen, ven, x, y, line_end, frame_start
    );

    modport slave (
        input hs, vs, hen, ven, x, y, line_end, frame_start
    );

endinterface

// File: rtl/vga_scan_timing_scan_counter.sv
// scan_counter: modulo-N up-counter with enable.
// Ports:
//   clk  - clock, rising edge
//   rstn - asynchronous active-low reset, clears the count
//   en   - advance the count this cycle
//   cnt  - current count, 0..N-1
//   tc   - terminal count (cnt == N-1), independent of en
module scan_counter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: free-running raster scan timing generator.
// Every output is a registered decode of the counters (one cycle latency).
// Ports:
//   clk  - pixel clock
//   rstn - asynchronous active-low reset
//   vga  - timing bundle (hs, vs, hen, ven, x, y, line_end, frame_start)
// Build option: define VGA_SCAN_COORD_EN to build the x/y coordinate
// registers; otherwise x and y are constant 0.
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned HSW      = DEF_HSW,
    parameter int unsigned HBP      = DEF_HBP,
    parameter int unsigned HACT     = DEF_HACT,
    parameter int unsigned HFP      = DEF_HFP,
    parameter int unsigned VSW      = DEF_VSW,
    parameter int unsigned VBP      = DEF_VBP,
    parameter int unsigned VACT     = DEF_VACT,
    parameter int unsigned VFP      = DEF_VFP,
    parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rstn,
    vga_scan_timing_if.master   vga
);

    localparam int unsigned HTOT = axis_total(HSW, HBP, HACT, HFP);
    localparam int unsigned VTOT = axis_total(VSW, VBP, VACT, VFP);
    localparam int unsigned CW   = 11;

    localparam logic [CW-1:0] H_SYNC_END = CW'(HSW);
    localparam logic [CW-1:0] H_ACT_BEG  = CW'(HSW + HBP);
    localparam logic [CW-1:0] H_ACT_END  = CW'(HSW + HBP + HACT);
    localparam logic [CW-1:0] V_SYNC_END = CW'(VSW);
    localparam logic [CW-1:0] V_ACT_BEG  = CW'(VSW + VBP);
    localparam logic [CW-1:0] V_ACT_END  = CW'(VSW + VBP + VACT);

    generate
        if (HSW < 1 || HBP < 1 || HACT < 1 || HFP < 1 ||
            VSW < 1 || VBP < 1 || VACT < 1 || VFP < 1) begin : g_bad_param
            $error("vga_scan_timing: every timing parameter must be >= 1");
        end
        if (HTOT >= (1 << CW)) begin : g_bad_htot
            $error("vga_scan_timing: HTOT must be < 2^11");
        end
        // Vertical counter shares the 11-bit width; y is only Y_W bits wide.
        if (VTOT >= (1 << CW) || VACT > (1 << Y_W)) begin : g_bad_vtot
            $error("vga_scan_timing: vertical timing exceeds counter/coordinate width");
        end
    endgenerate

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_tc;
    logic          v_tc;

    scan_counter #(
        .N (HTOT),
        .W (CW)
    ) u_hcnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (1'b1),
        .cnt  (hcnt),
        .tc   (h_tc)
    );

    scan_counter #(
        .N (VTOT),
        .W (CW)
    ) u_vcnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (h_tc),
        .cnt  (vcnt),
        .tc   (v_tc)
    );

    // Decodes of the current counter values; registered below.
    logic hs_d;
    logic vs_d;
    logic hen_d;
    logic ven_d;

    always_comb begin
        hs_d  = (hcnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (vcnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        hen_d = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END);
        ven_d = (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);
    end

    logic hs_q;
    logic vs_q;
    logic hen_q;
    logic ven_q;
    logic line_end_q;
    logic frame_start_q;
    // High while the counters sit at (0,0); reset to 1 because reset puts them there.
    logic origin_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            hen_q         <= 1'b0;
            ven_q         <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            origin_q      <= 1'b1;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hen_q         <= hen_d;
            ven_q         <= ven_d;
            // Falling edge of the combined window; hen_q is 0 after reset so a
            // truncated line never produces a pulse.
            line_end_q    <= hen_q & ven_q & ~(hen_d & ven_d);
            frame_start_q <= origin_q;
            origin_q      <= h_tc & v_tc;
        end
    end

    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.hen         = hen_q;
    assign vga.ven         = ven_q;
    assign vga.line_end    = line_end_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_SCAN_COORD_EN
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= hen_d ? X_W'(hcnt - H_ACT_BEG) : '0;
            y_q <= ven_d ? Y_W'(vcnt - V_ACT_BEG) : '0;
        end
    end

    assign vga.x = x_q;
    assign vga.y = y_q;
`else
    assign vga.x = '0;
    assign vga.y = '0;
`endif

endmodule
